// File: rtl/vita_sched_pkg.sv
// Shared types for the VITA-timed pulse scheduler: command record, FSM states, wave codes.
// The late-command policy is selected in the top by SCHED_LATE_DROP_EN.
package vita_sched_pkg;

    // Commands store the pulse count at its widest so the record layout is fixed.
    localparam int NP_W_MAX = 32;

    localparam logic [2:0] WAVE_CHIRP = 3'd0;
    localparam logic [2:0] WAVE_TONE  = 3'd1;
    localparam logic [2:0] WAVE_RAMP  = 3'd2;

    typedef struct packed {
        logic [63:0]         trig_time;
        logic [31:0]         len_pri;
        logic [31:0]         duration;
        logic [2:0]          wave_type;
        logic [NP_W_MAX-1:0] npulses;
    } sched_cmd_t;

    localparam int SCHED_CMD_W = $bits(sched_cmd_t);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARM   = 2'd1,
        RUN   = 2'd2,
        DRAIN = 2'd3
    } sched_state_t;

    // A train with no beats or no pulses completes without ever running.
    function automatic logic is_null_cmd(input sched_cmd_t c);
        return (c.len_pri == 32'd0) || (c.npulses == '0);
    endfunction

endpackage

// File: rtl/sched_cmd_fifo.sv
// Synchronous command FIFO with occupancy output; no write bypass when full.
// The head is read combinationally so the scheduler can pop and load in one cycle.
module sched_cmd_fifo
    import vita_sched_pkg::*;
#(
    parameter int DEPTH = 4
)(
    input  logic                   sClk,
    input  logic                   reset,
    input  logic                   i_push,
    output logic                   o_ready,
    input  logic [SCHED_CMD_W-1:0] i_data,
    input  logic                   i_pop,
    output logic [SCHED_CMD_W-1:0] o_head,
    output logic                   o_empty,
    output logic [$clog2(DEPTH):0] o_level
);

    localparam int AW = $clog2(DEPTH);

    logic [SCHED_CMD_W-1:0] r_mem [DEPTH];
    logic [AW-1:0]          r_wr_ptr;
    logic [AW-1:0]          r_rd_ptr;
    logic [AW:0]            r_level;
    logic                   w_full;
    logic                   w_push;
    logic                   w_pop;

    assign w_full  = (r_level == (AW+1)'(DEPTH));
    assign o_empty = (r_level == '0);
    assign o_ready = !w_full;
    assign o_level = r_level;
    assign o_head  = r_mem[r_rd_ptr];
    assign w_push  = i_push && !w_full;
    assign w_pop   = i_pop && !o_empty;

    always_ff @(posedge sClk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

    always_ff @(posedge sClk) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_level <= r_level + (AW+1)'(1);
                2'b01:   r_level <= r_level - (AW+1)'(1);
                default: r_level <= r_level;
            endcase
        end
    end

endmodule

// File: rtl/vita_pulse_sched.sv
// Buffers timed pulse-train commands and releases each to the generator at its VITA time.
// Define SCHED_LATE_DROP_EN to discard late commands instead of firing them immediately.
module vita_pulse_sched
    import vita_sched_pkg::*;
#(
    parameter int DEPTH     = 4,
    parameter int NP_W      = 16,
    parameter int DRAIN_CYC = 2
)(
    input  logic                   sClk,
    input  logic                   reset,
    input  logic                   cmd_valid,
    output logic                   cmd_ready,
    input  logic [63:0]            cmd_time,
    input  logic [31:0]            cmd_len_pri,
    input  logic [31:0]            cmd_duration,
    input  logic [2:0]             cmd_type,
    input  logic [NP_W-1:0]        cmd_npulses,
    input  logic [63:0]            vita_time,
    input  logic                   mon_tvalid,
    input  logic                   mon_tready,
    input  logic                   abort,
    output logic                   sRun,
    output logic [31:0]            len_PRI,
    output logic [31:0]            duration_wave,
    output logic [2:0]             type_wave,
    output logic [63:0]            vita_time_trigger,
    output logic                   busy,
    output logic [$clog2(DEPTH):0] fifo_level,
    output logic                   done_pulse,
    output logic                   late_pulse,
    output logic                   abort_pulse
);

    localparam int DW = $clog2(DRAIN_CYC + 1);

    sched_state_t          r_state;
    sched_state_t          w_state_next;
    sched_cmd_t            r_act;
    sched_cmd_t            w_cmd_in;
    sched_cmd_t            w_head;
    logic [NP_W_MAX-1:0]   w_np_ext;
    logic [NP_W_MAX-1:0]   w_pulse_ext;
    logic [SCHED_CMD_W-1:0] w_head_flat;
    logic                  w_fifo_empty;
    logic                  w_pop;
    logic                  w_beat;
    logic                  w_last_beat;
    logic                  w_last_pulse;
    logic                  w_train_end;
    logic                  w_null_cmd;
    logic                  w_is_late;
    logic                  w_time_hit;
    logic                  w_drain_end;
    logic                  w_srun_next;
    logic                  w_done_next;
    logic                  w_late_next;
    logic                  w_abort_next;
    logic                  r_srun;
    logic                  r_done;
    logic                  r_late;
    logic                  r_abort;
    logic                  r_first_arm;
    logic [31:0]           r_beat_cnt;
    logic [NP_W-1:0]       r_pulse_cnt;
    logic [DW-1:0]         r_drain_cnt;

    always_comb begin
        w_np_ext              = '0;
        w_np_ext[NP_W-1:0]    = cmd_npulses;
        w_pulse_ext           = '0;
        w_pulse_ext[NP_W-1:0] = r_pulse_cnt;
    end

    assign w_cmd_in = '{trig_time: cmd_time, len_pri: cmd_len_pri, duration: cmd_duration,
                        wave_type: cmd_type, npulses: w_np_ext};
    assign w_head   = w_head_flat;

    sched_cmd_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .sClk    (sClk),
        .reset   (reset),
        .i_push  (cmd_valid),
        .o_ready (cmd_ready),
        .i_data  (w_cmd_in),
        .i_pop   (w_pop),
        .o_head  (w_head_flat),
        .o_empty (w_fifo_empty),
        .o_level (fifo_level)
    );

    assign w_beat       = mon_tvalid && mon_tready;
    assign w_last_beat  = (r_beat_cnt == r_act.len_pri - 32'd1);
    assign w_last_pulse = (w_pulse_ext == r_act.npulses - 32'd1);
    assign w_train_end  = w_beat && w_last_beat && w_last_pulse;
    assign w_null_cmd   = is_null_cmd(r_act);
    // Lateness is judged only on the first ARM cycle; later cycles simply wait for the time.
    assign w_is_late    = r_first_arm && (r_act.trig_time < vita_time);
    assign w_time_hit   = (vita_time >= r_act.trig_time);
    assign w_drain_end  = (r_drain_cnt == DW'(DRAIN_CYC - 1));

    always_ff @(posedge sClk) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_pop        = 1'b0;
        case (r_state)
            IDLE: begin
                if (!w_fifo_empty) begin
                    w_pop        = 1'b1;
                    w_state_next = ARM;
                end
            end
            ARM: begin
                if (abort || w_null_cmd) begin
                    w_state_next = DRAIN;
                end else if (w_is_late) begin
`ifdef SCHED_LATE_DROP_EN
                    w_state_next = DRAIN;
`else
                    w_state_next = RUN;
`endif
                end else if (w_time_hit) begin
                    w_state_next = RUN;
                end
            end
            RUN: begin
                if (abort || w_train_end) begin
                    w_state_next = DRAIN;
                end
            end
            DRAIN: begin
                if (w_drain_end) begin
                    w_state_next = IDLE;
                end
            end
            default: w_state_next = IDLE;
        endcase
    end

    // sRun is a registered copy of "next state is RUN", so it rises one cycle after the fire decision.
    always_comb begin
        busy         = (r_state != IDLE);
        w_srun_next  = (w_state_next == RUN);
        w_abort_next = abort && ((r_state == ARM) || (r_state == RUN));
        w_done_next  = !abort && (((r_state == ARM) && w_null_cmd) ||
                                  ((r_state == RUN) && w_train_end));
        w_late_next  = !abort && (r_state == ARM) && !w_null_cmd && w_is_late;
    end

    always_ff @(posedge sClk) begin
        if (reset) begin
            r_act       <= '0;
            r_srun      <= 1'b0;
            r_done      <= 1'b0;
            r_late      <= 1'b0;
            r_abort     <= 1'b0;
            r_first_arm <= 1'b0;
            r_beat_cnt  <= '0;
            r_pulse_cnt <= '0;
            r_drain_cnt <= '0;
        end else begin
            r_srun      <= w_srun_next;
            r_done      <= w_done_next;
            r_late      <= w_late_next;
            r_abort     <= w_abort_next;
            r_first_arm <= w_pop;
            if (w_pop) begin
                r_act <= w_head;
            end
            if (r_state != RUN) begin
                r_beat_cnt  <= '0;
                r_pulse_cnt <= '0;
            end else if (w_beat) begin
                if (w_last_beat) begin
                    r_beat_cnt  <= '0;
                    r_pulse_cnt <= r_pulse_cnt + NP_W'(1);
                end else begin
                    r_beat_cnt <= r_beat_cnt + 32'd1;
                end
            end
            if (r_state == DRAIN) begin
                r_drain_cnt <= r_drain_cnt + DW'(1);
            end else begin
                r_drain_cnt <= '0;
            end
        end
    end

    assign sRun              = r_srun;
    assign len_PRI           = r_act.len_pri;
    assign duration_wave     = r_act.duration;
    assign type_wave         = r_act.wave_type;
    assign vita_time_trigger = r_act.trig_time;
    assign done_pulse        = r_done;
    assign late_pulse        = r_late;
    assign abort_pulse       = r_abort;

endmodule

// File: tb/tb_vita_pulse_sched.sv
// Directed bench for vita_pulse_sched with a scoreboard of expected done/late/abort events.
module tb_vita_pulse_sched;
    import vita_sched_pkg::*;

    localparam int DEPTH     = 4;
    localparam int NP_W      = 16;
    localparam int DRAIN_CYC = 2;
    localparam int EV_LATE   = 1;
    localparam int EV_DONE   = 2;
    localparam int EV_ABORT  = 3;

    logic                   sClk = 1'b0;
    logic                   reset = 1'b1;
    logic                   cmd_valid = 1'b0;
    logic                   cmd_ready;
    logic [63:0]            cmd_time = '0;
    logic [31:0]            cmd_len_pri = '0;
    logic [31:0]            cmd_duration = '0;
    logic [2:0]             cmd_type = '0;
    logic [NP_W-1:0]        cmd_npulses = '0;
    logic [63:0]            vita_time = '0;
    logic                   mon_tvalid = 1'b0;
    logic                   mon_tready = 1'b0;
    logic                   abort = 1'b0;
    logic                   sRun;
    logic [31:0]            len_PRI;
    logic [31:0]            duration_wave;
    logic [2:0]             type_wave;
    logic [63:0]            vita_time_trigger;
    logic                   busy;
    logic [$clog2(DEPTH):0] fifo_level;
    logic                   done_pulse;
    logic                   late_pulse;
    logic                   abort_pulse;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int beats = 0;
    int q[$];

    vita_pulse_sched #(.DEPTH(DEPTH), .NP_W(NP_W), .DRAIN_CYC(DRAIN_CYC)) dut (
        .sClk(sClk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_time(cmd_time), .cmd_len_pri(cmd_len_pri), .cmd_duration(cmd_duration),
        .cmd_type(cmd_type), .cmd_npulses(cmd_npulses), .vita_time(vita_time),
        .mon_tvalid(mon_tvalid), .mon_tready(mon_tready), .abort(abort), .sRun(sRun),
        .len_PRI(len_PRI), .duration_wave(duration_wave), .type_wave(type_wave),
        .vita_time_trigger(vita_time_trigger), .busy(busy), .fifo_level(fifo_level),
        .done_pulse(done_pulse), .late_pulse(late_pulse), .abort_pulse(abort_pulse)
    );

    always #5 sClk = ~sClk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic sb_check(input string tag, input int got);
        int exp;
        exp = (q.size() > 0) ? q.pop_front() : 0;
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL sb_%s observed=%0d expected=%0d", tag, got, exp);
        end
        $display("t=%0t event %s (cyc %0d)", $time, tag, cyc);
    endtask

    // One clock: advance time, count consumed beats, score pulses, set next beat strobe.
    task automatic tick();
        logic b;
        b = sRun && mon_tvalid && mon_tready;
        @(posedge sClk);
        #1;
        if (b) beats++;
        cyc++;
        vita_time = vita_time + 64'd1;
        if (late_pulse)  sb_check("late", EV_LATE);
        if (abort_pulse) sb_check("abort", EV_ABORT);
        if (done_pulse)  sb_check("done", EV_DONE);
        mon_tvalid = (cyc % 3 == 0);
        mon_tready = mon_tvalid;
    endtask

    task automatic wait_srun(input logic lvl, input int max, output int n);
        n = 0;
        while (sRun !== lvl && n < max) begin
            tick();
            n++;
        end
        chk("wait_srun", sRun, lvl);
    endtask

    task automatic set_cmd(input logic [63:0] t, input logic [31:0] len, input logic [31:0] dur,
                           input logic [2:0] typ, input logic [NP_W-1:0] np);
        cmd_time = t; cmd_len_pri = len; cmd_duration = dur; cmd_type = typ; cmd_npulses = np;
    endtask

    task automatic push_one(input int ev);
        cmd_valid = 1'b1;
        q.push_back(ev);
        tick();
        cmd_valid = 1'b0;
    endtask

    task automatic settle();
        repeat (4) tick();
    endtask

    initial begin
        int n;
        int acc;
        int g;
        logic r;
        logic seen;
        logic [63:0] base;
        logic [63:0] t0;

        // Reset state
        reset = 1'b1;
        tick(); tick();
        reset = 1'b0;
        tick();
        chk("rst_srun", sRun, 0);
        chk("rst_ready", cmd_ready, 1);
        chk("rst_level", fifo_level, 0);
        chk("rst_busy", busy, 0);
        chk("rst_len", len_PRI, 0);
        chk("rst_trig", vita_time_trigger, 0);

        // Basic train: fires at time 100, 3 PRIs of 4 beats
        vita_time = 64'd50;
        set_cmd(64'd100, 32'd4, 32'd2, WAVE_TONE, 16'd3);
        push_one(EV_DONE);
        beats = 0;
        wait_srun(1'b1, 100, n);
        chk("rise_vita", vita_time, 101);
        chk("trig", vita_time_trigger, 100);
        chk("len", len_PRI, 4);
        chk("dur", duration_wave, 2);
        chk("type", type_wave, 1);
        chk("busy_run", busy, 1);
        wait_srun(1'b0, 100, n);
        chk("beats12", beats, 12);
        chk("done_at_fall", done_pulse, 1);
        tick();
        chk("done_1cyc", done_pulse, 0);
        chk("busy_drain", busy, 1);
        tick();
        chk("busy_idle", busy, 0);
        chk("q_empty_1", q.size(), 0);

        // Five back-to-back commands into a 4-deep FIFO
        settle();
        base = vita_time + 64'd200;
        acc = 0;
        cmd_valid = 1'b1;
        for (int k = 0; k < 6; k++) begin
            set_cmd(base + 64'(100 * acc), 32'd2, 32'd1, WAVE_CHIRP, 16'd1);
            r = cmd_ready;
            tick();
            if (r) begin
                acc++;
                q.push_back(EV_DONE);
            end
        end
        cmd_valid = 1'b0;
        chk("accepted", acc, 5);
        chk("full_ready", cmd_ready, 0);
        chk("full_level", fifo_level, 4);
        for (int k = 0; k < 5; k++) begin
            wait_srun(1'b1, 600, n);
            if (k > 0) chk("gap_ge2", (n >= 2), 1);
            chk("order_trig", vita_time_trigger, base + 64'(100 * k));
            wait_srun(1'b0, 100, n);
        end
        chk("q_empty_2", q.size(), 0);

        // Late command
        settle();
        vita_time = 64'd20;
        set_cmd(64'd10, 32'd2, 32'd1, WAVE_RAMP, 16'd1);
        q.push_back(EV_LATE);
`ifndef SCHED_LATE_DROP_EN
        q.push_back(EV_DONE);
`endif
        cmd_valid = 1'b1;
        tick();
        cmd_valid = 1'b0;
        tick();
        chk("late_arm_busy", busy, 1);
        chk("late_arm_srun", sRun, 0);
        tick();
        chk("late_pulse", late_pulse, 1);
`ifdef SCHED_LATE_DROP_EN
        chk("late_drop_srun", sRun, 0);
        seen = 1'b0;
        repeat (8) begin
            tick();
            if (sRun) seen = 1'b1;
        end
        chk("late_drop_never", seen, 0);
`else
        chk("late_fire_srun", sRun, 1);
        wait_srun(1'b0, 100, n);
`endif
        settle();
        chk("q_empty_3", q.size(), 0);

        // Abort at beat 5 of A, then abort on B's final beat
        t0 = vita_time + 64'd10;
        set_cmd(t0, 32'd4, 32'd1, WAVE_CHIRP, 16'd2);
        push_one(EV_ABORT);
        set_cmd(t0 + 64'd60, 32'd2, 32'd1, WAVE_TONE, 16'd1);
        push_one(EV_ABORT);
        wait_srun(1'b1, 100, n);
        beats = 0;
        g = 0;
        while (beats < 4 && g < 100) begin tick(); g++; end
        g = 0;
        while (!(mon_tvalid && mon_tready) && g < 10) begin tick(); g++; end
        chk("beat5_pos", beats, 4);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("abort_srun", sRun, 0);
        chk("abort_pulse", abort_pulse, 1);
        chk("abort_nodone", done_pulse, 0);
        wait_srun(1'b1, 200, n);
        chk("next_trig", vita_time_trigger, t0 + 64'd60);
        beats = 0;
        g = 0;
        while (beats < 1 && g < 100) begin tick(); g++; end
        g = 0;
        while (!(mon_tvalid && mon_tready) && g < 10) begin tick(); g++; end
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("abort_final_srun", sRun, 0);
        chk("abort_final_pulse", abort_pulse, 1);
        chk("abort_final_nodone", done_pulse, 0);
        settle();
        chk("q_empty_4", q.size(), 0);

        // Null commands: np=0 and len_pri=0
        set_cmd(vita_time + 64'd3, 32'd4, 32'd1, WAVE_CHIRP, 16'd0);
        push_one(EV_DONE);
        set_cmd(vita_time + 64'd3, 32'd0, 32'd1, WAVE_CHIRP, 16'd3);
        push_one(EV_DONE);
        seen = 1'b0;
        repeat (15) begin
            tick();
            if (sRun) seen = 1'b1;
        end
        chk("null_never_run", seen, 0);
        chk("null_idle", busy, 0);
        chk("q_empty_5", q.size(), 0);

        // Reset in the middle of a train with another queued
        set_cmd(vita_time + 64'd3, 32'd4, 32'd1, WAVE_TONE, 16'd5);
        push_one(EV_DONE);
        push_one(EV_DONE);
        wait_srun(1'b1, 50, n);
        repeat (4) tick();
        reset = 1'b1;
        q.delete();
        tick();
        reset = 1'b0;
        chk("mrst_srun", sRun, 0);
        chk("mrst_level", fifo_level, 0);
        chk("mrst_busy", busy, 0);
        chk("mrst_pulses", {done_pulse, late_pulse, abort_pulse}, 0);
        tick();
        chk("mrst_ready", cmd_ready, 1);
        seen = 1'b0;
        repeat (10) begin
            tick();
            if (sRun) seen = 1'b1;
        end
        chk("mrst_quiet", seen, 0);
        chk("q_empty_end", q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/vita_pulse_sched.md
Name: vita_pulse_sched

Overview:
- Upstream stage of the waveform generator. Accepts timed pulse-train commands, buffers them, and releases each at its VITA trigger time.
- Each command is driven onto the generator's sRun/len_PRI/duration_wave/type_wave/vita_time_trigger inputs.
- Counts accepted output beats on a tap of the generator stream to decide when a train of N PRIs is complete.
- Enforces a quiet gap between trains so the generator returns to its parameter-wait state.

Parameters:
- DEPTH, 4, command FIFO entries (power of 2, ≥2).
- NP_W, 16, width of pulse-count field.
- DRAIN_CYC, 2, cycles sRun is held low after each train (≥2).

Ports:
- sClk  in  1  clock.
- reset  in  1  synchronous, active-high.
- cmd_valid  in  1  command offer.
- cmd_ready  out  1  FIFO not full.
- cmd_time  in  64  VITA trigger time.
- cmd_len_pri  in  32  beats per PRI.
- cmd_duration  in  32  active beats per PRI.
- cmd_type  in  3  0 chirp, 1 tone, 2 ramp.
- cmd_npulses  in  NP_W  PRIs in train.
- vita_time  in  64  free-running time.
- mon_tvalid  in  1  tap of generator o_tvalid.
- mon_tready  in  1  tap of generator o_tready.
- abort  in  1  kill active train.
- sRun  out  1  generator run.
- len_PRI  out  32  to generator.
- duration_wave  out  32  to generator.
- type_wave  out  3  to generator.
- vita_time_trigger  out  64  to generator.
- busy  out  1  state != IDLE.
- fifo_level  out  $clog2(DEPTH)+1  occupancy.
- done_pulse  out  1  1-cycle, train completed.
- late_pulse  out  1  1-cycle, late command detected.
- abort_pulse  out  1  1-cycle, train aborted.

Behaviour:
- Reset: sRun=0, all parameter outputs=0, FIFO empty, fifo_level=0, state IDLE, all pulses 0, cmd_ready=1 in the cycle after reset. Reset mid-train drops everything with no pulses.
- FIFO:
  - Push on cmd_valid&&cmd_ready.
  - cmd_ready = !full; no bypass when full, even on a same-cycle pop.
  - Push and pop in the same cycle leave the level unchanged.
- States:
  - IDLE: if FIFO is non-empty, pop the head into the active registers, load the parameter outputs, and go to ARM. Parameter outputs change only on a pop.
  - ARM:
    - len_pri==0 or npulses==0: done_pulse, go to DRAIN.
    - act_time < vita_time (strict) on the first ARM cycle: late_pulse. Handling follows the optional feature.
    - Otherwise wait until vita_time >= act_time, then go to RUN with sRun=1 registered. sRun rises the cycle after the compare is true.
  - RUN:
    - A beat is mon_tvalid&&mon_tready.
    - beat_cnt counts 0..len_pri-1 and wraps; pulse_cnt increments on each wrap.
    - On the last beat of pulse npulses-1: sRun<=0, done_pulse, go to DRAIN.
    - beat_cnt and pulse_cnt are 32-bit/NP_W-bit unsigned; no saturation is needed because termination precedes overflow.
  - DRAIN: sRun=0 for DRAIN_CYC cycles, then go to IDLE.
- abort:
  - In ARM or RUN: sRun<=0 next cycle, abort_pulse, go to DRAIN. The FIFO contents are retained.
  - In IDLE or DRAIN: ignored.
  - abort coincident with the final beat: abort wins, no done_pulse.
- busy is high in ARM, RUN and DRAIN.

Optional Feature:
- Macro SCHED_LATE_DROP_EN.
- Defined: a late command is discarded (late_pulse, go to DRAIN, sRun never rises).
- Undefined: a late command fires immediately (late_pulse, and sRun rises in the next cycle as normal).

Decomposition:
- Package vita_sched_pkg:
  - sched_cmd_t struct (time, len_pri, duration, type, npulses).
  - sched_state_t enum {IDLE, ARM, RUN, DRAIN}.
  - Wave-type constants WAVE_CHIRP=0, WAVE_TONE=1, WAVE_RAMP=2.
- Sub-module sched_cmd_fifo: sync FIFO of sched_cmd_t with level output.

Test Plan:
- Push {time=100, len_pri=4, dur=2, type=1, np=3} at vita_time=50, mon_tvalid&&mon_tready every 3rd cycle:
  - sRun rises the cycle after vita_time reaches 100 and falls after the 12th beat.
  - done_pulse 1 cycle; busy low DRAIN_CYC cycles later.
- Push 5 commands back-to-back with DEPTH=4 while ARM waits on a far time:
  - Accepts 5 (first popped immediately), then cmd_ready=0 with fifo_level=4.
  - Trains execute in order, with sRun low ≥2 cycles between them.
- Command time=10 at vita_time=20:
  - late_pulse.
  - With SCHED_LATE_DROP_EN, sRun stays 0.
  - Without it, sRun rises 1 cycle after ARM.
- abort asserted at beat 5 of np=2, len_pri=4: sRun falls next cycle, abort_pulse, no done_pulse, next queued command still runs.
- np=0 or len_pri=0 command: done_pulse, sRun never asserts; reset asserted mid-RUN: sRun=0, fifo_level=0, no pulses.
